// File: rtl/pipe_stall_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_stall_ctrl_pkg
// Definitions shared by the pipeline stall controller and its watchdog:
//   - stall_state_t   : controller state (RUN, MEM_WAIT, ERROR)
//   - DEF_MEM_TIMEOUT : default number of consecutive memory-stall cycles
//                       before the watchdog trips (0 disables it)
//   - STALL_CNT_W     : width of the stall-cycle performance counter
//   - FLUSH_CNT_W     : width of the flush performance counter
// -----------------------------------------------------------------------------
package pipe_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } stall_state_t;

    localparam int DEF_MEM_TIMEOUT = 15;
    localparam int STALL_CNT_W     = 32;
    localparam int FLUSH_CNT_W     = 16;

endpackage

// File: rtl/pipe_stall_ctrl_stall_watchdog.sv
// -----------------------------------------------------------------------------
// stall_watchdog
// Counts consecutive memory-stall cycles and flags the cycle in which the
// count (including the current cycle) reaches MEM_TIMEOUT.
//
// Parameters:
//   MEM_TIMEOUT  consecutive stall cycles allowed; 0 disables the watchdog
// Ports:
//   clk          pipeline clock
//   rst          synchronous active-high reset
//   mem_stall    MEM stage is waiting on the SRAM this cycle
//   halted       controller is in ERROR; counting stops
//   timeout_hit  this stall cycle is the MEM_TIMEOUT-th consecutive one
// -----------------------------------------------------------------------------
module stall_watchdog
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_stall,
    input  logic halted,
    output logic timeout_hit
);

    // A zero timeout would give a zero-width counter; keep one bit instead.
    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    logic [CW-1:0] wait_cnt;
    logic [CW-1:0] stall_cnt;

    // wait_cnt is zero whenever the previous cycle did not stall (i.e. in RUN),
    // so the stall that enters MEM_WAIT yields a count of 1.
    always_comb begin
        stall_cnt   = wait_cnt + CW'(1);
        timeout_hit = (MEM_TIMEOUT != 0) && mem_stall && !halted &&
                      (stall_cnt == CW'(MEM_TIMEOUT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if ((MEM_TIMEOUT == 0) || !mem_stall || halted) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= stall_cnt;
        end
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_stall_ctrl
// Enforcement end of the hazard protocol: turns the hazard unit's freeze
// request, the EXE branch outcome and the MEM-stage SRAM handshake into the
// per-register enable/flush/bubble controls of the 5-stage pipeline, and
// guards multi-cycle memory accesses with a watchdog.
//
// Optional feature macro: STALL_PERF_CNT_EN
//   defined   - stall_cycles / flush_count are saturating performance counters
//   undefined - both counter outputs are tied to 0, no counter flops exist
//
// Parameters:
//   MEM_TIMEOUT   consecutive memory-stall cycles before ERROR (0 = off)
// Ports:
//   clk, rst      pipeline clock, synchronous active-high reset
//   freez         hazard freeze request (same cycle)
//   branch_taken  EXE-stage branch resolved taken
//   mem_req       MEM stage performs a load/store this cycle
//   mem_ready     SRAM completes the access this cycle
//   pc_en         PC load enable
//   if_id_en      IF/ID load enable
//   if_id_flush   IF/ID loads a NOP
//   id_ex_bubble  ID/EX loads a NOP
//   ex_mem_en     EX/MEM load enable
//   mem_wb_en     MEM/WB load enable
//   mem_timeout   sticky watchdog error
//   stall_cycles  cycles with pc_en low (outside reset)
//   flush_count   cycles with if_id_flush high (outside reset)
// -----------------------------------------------------------------------------
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   freez,
    input  logic                   branch_taken,
    input  logic                   mem_req,
    input  logic                   mem_ready,
    output logic                   pc_en,
    output logic                   if_id_en,
    output logic                   if_id_flush,
    output logic                   id_ex_bubble,
    output logic                   ex_mem_en,
    output logic                   mem_wb_en,
    output logic                   mem_timeout,
    output logic [STALL_CNT_W-1:0] stall_cycles,
    output logic [FLUSH_CNT_W-1:0] flush_count
);

    stall_state_t state_q;
    stall_state_t state_d;
    logic         mem_stall;
    logic         timeout_hit;

    assign mem_stall = mem_req & ~mem_ready;

    stall_watchdog #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_watchdog (
        .clk         (clk),
        .rst         (rst),
        .mem_stall   (mem_stall),
        .halted      (state_q == ERROR),
        .timeout_hit (timeout_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state. MEM_WAIT lasts exactly as long as mem_stall holds, so
    // leaving it covers both mem_ready and mem_req dropping.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (timeout_hit)    state_d = ERROR;
                else if (mem_stall) state_d = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (timeout_hit)     state_d = ERROR;
                else if (!mem_stall) state_d = RUN;
            end
            ERROR:   state_d = ERROR;
            default: state_d = RUN;
        endcase
    end

    // Mealy pipeline controls. The memory stall outranks a taken branch:
    // EXE holds, so the branch is seen again once the access completes.
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if (rst) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            ex_mem_en    = 1'b0;
            mem_wb_en    = 1'b0;
        end else if (state_q == ERROR || mem_stall) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else if (branch_taken) begin
            // The ID instruction is discarded, so a pending freeze is moot.
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (freez) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    // ERROR is only left through reset, so the state itself is the sticky flag.
    assign mem_timeout = (state_q == ERROR);

`ifdef STALL_PERF_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cycles_q;
    logic [FLUSH_CNT_W-1:0] flush_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (!pc_en && (stall_cycles_q != '1)) begin
                stall_cycles_q <= stall_cycles_q + STALL_CNT_W'(1);
            end
            if (if_id_flush && (flush_count_q != '1)) begin
                flush_count_q <= flush_count_q + FLUSH_CNT_W'(1);
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_stall_ctrl
// Directed scenarios followed by randomized traffic, each cycle compared with a
// cycle-level reference model of the stall protocol kept in this bench.
// -----------------------------------------------------------------------------
module tb_pipe_stall_ctrl;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        freez = 1'b0;
    logic        branch_taken = 1'b0;
    logic        mem_req = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pc_en;
    logic        if_id_en;
    logic        if_id_flush;
    logic        id_ex_bubble;
    logic        ex_mem_en;
    logic        mem_wb_en;
    logic        mem_timeout;
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(
        .MEM_TIMEOUT (N)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .freez        (freez),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .pc_en        (pc_en),
        .if_id_en     (if_id_en),
        .if_id_flush  (if_id_flush),
        .id_ex_bubble (id_ex_bubble),
        .ex_mem_en    (ex_mem_en),
        .mem_wb_en    (mem_wb_en),
        .mem_timeout  (mem_timeout),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

    int      compared   = 0;
    int      mismatched = 0;

    // Reference model state: length of the current run of stalled memory
    // cycles, whether the watchdog has fired, and the two event tallies.
    int      run_len = 0;
    bit      err     = 1'b0;
    longint  m_stall = 0;
    longint  m_flush = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs, compare outputs mid-cycle, advance model.
    task automatic step(input string tag, input logic r, input logic f,
                        input logic b, input logic q, input logic y);
        logic [5:0]  exp_ctrl;   // {pc, if_id, flush, bubble, ex_mem, mem_wb}
        logic [31:0] exp_sc;
        logic [31:0] exp_fc;
        logic        ms;
        rst = r; freez = f; branch_taken = b; mem_req = q; mem_ready = y;
        @(negedge clk);
        ms = q & ~y;
        if (r)               exp_ctrl = 6'b001100;
        else if (err || ms)  exp_ctrl = 6'b000000;
        else if (b)          exp_ctrl = 6'b111111;
        else if (f)          exp_ctrl = 6'b000111;
        else                 exp_ctrl = 6'b110011;
`ifdef STALL_PERF_CNT_EN
        exp_sc = 32'(m_stall);
        exp_fc = 32'(m_flush);
`else
        exp_sc = 32'd0;
        exp_fc = 32'd0;
`endif
        check({tag, ":ctrl"}, 32'({pc_en, if_id_en, if_id_flush, id_ex_bubble,
                                   ex_mem_en, mem_wb_en}), 32'(exp_ctrl));
        check({tag, ":timeout"}, 32'(mem_timeout), 32'(err));
        check({tag, ":stall_cycles"}, stall_cycles, exp_sc);
        check({tag, ":flush_count"}, 32'(flush_count), exp_fc);
        @(posedge clk);
        if (r) begin
            err = 1'b0; run_len = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (!exp_ctrl[5] && m_stall < 64'hFFFF_FFFF) m_stall++;
            if (exp_ctrl[3] && m_flush < 65535)          m_flush++;
            if (!err) begin
                if (ms) begin
                    run_len++;
                    if (run_len >= N) err = 1'b1;
                end else begin
                    run_len = 0;
                end
            end
        end
        #1;
    endtask

    initial begin
        // Reset held two cycles, then free running
        step("rst0", 1, 0, 0, 0, 0);
        step("rst1", 1, 0, 0, 0, 0);
        step("idle", 0, 0, 0, 0, 0);
        // Load-use freeze for one cycle
        step("loaduse", 0, 1, 0, 0, 0);
        step("after_lu", 0, 0, 0, 0, 0);
        // Branch together with a freeze
        step("br_frz", 0, 1, 1, 0, 0);
        step("after_br", 0, 0, 0, 0, 0);
        // Access completing in its first cycle: no stall
        step("mem_fast", 0, 0, 0, 1, 1);
        // Three wait cycles, then ready
        step("mw1", 0, 0, 0, 1, 0);
        step("mw2", 0, 0, 0, 1, 0);
        step("mw3", 0, 0, 0, 1, 0);
        step("mw_rdy", 0, 0, 0, 1, 1);
        step("mw_run", 0, 0, 0, 0, 0);
        // Stall with a taken branch for two cycles, branch issues on ready
        step("sb1", 0, 0, 1, 1, 0);
        step("sb2", 0, 0, 1, 1, 0);
        step("sb_rdy", 0, 0, 1, 1, 1);
        // mem_req dropping also releases MEM_WAIT
        step("drop1", 0, 0, 0, 1, 0);
        step("drop2", 0, 0, 0, 0, 0);
        // Three stalls stay below the watchdog threshold
        for (int i = 0; i < 3; i++) step("under", 0, 0, 0, 1, 0);
        step("under_rdy", 0, 0, 0, 1, 1);
        // Watchdog: stall forever, error from the fifth cycle and held
        for (int i = 0; i < 8; i++) step("wdog", 0, i[0], i[1], 1, 0);
        step("err_rdy", 0, 1, 1, 1, 1);
        step("err_idle", 0, 0, 0, 0, 0);
        // One reset cycle clears the error
        step("err_rst", 1, 0, 0, 1, 0);
        step("post_rst", 0, 0, 0, 0, 0);
        step("post_frz", 0, 1, 0, 0, 0);
        // Reset while in MEM_WAIT
        step("mwr1", 0, 0, 0, 1, 0);
        step("mwr_rst", 1, 0, 0, 1, 0);
        step("mwr_after", 0, 0, 0, 1, 1);
        // Randomized traffic with occasional resets
        for (int i = 0; i < 500; i++) begin
            step("rand",
                 ($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 3) != 0));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
